// File: rtl/aes_board_ctrl.sv
// Board front-end for the AES-128 core. It synchronises and debounces the
// push-buttons, builds the core text from a base value plus switches, and
// issues enc/dec starts against the core ready handshake. It also keeps the
// last result in a pageable LED window and stretches the done pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for an enc/dec press; text_o is latched on acceptance
// S_REQ  | request latched, waiting for core_ready_i before the start pulse
// S_BUSY | core running, waiting for core_done_i to capture the result
module aes_board_ctrl #(
  parameter int                      DATA_W          = 128,
  parameter int                      SW_W            = 4,
  parameter int                      LED_W           = 4,
  parameter logic [DATA_W-SW_W-1:0]  BASE_TEXT       = 124'h3243f6a8885a308d313198a2e037071,
  parameter int                      SYNC_STAGES     = 2,
  parameter int                      DEBOUNCE_CYCLES = 1_000_000,
  parameter int                      STRETCH_CYCLES  = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn_enc,
  input  logic              btn_dec,
  input  logic              btn_page,
  input  logic              core_ready_i,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_text_i,
  output logic              start_enc_o,
  output logic              start_dec_o,
  output logic [DATA_W-1:0] text_o,
  output logic [LED_W-1:0]  led,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int N_BTN = 3;
  localparam int B_ENC = 0;
  localparam int B_DEC = 1;
  localparam int B_PAGE = 2;

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int              ST_W    = $clog2(STRETCH_CYCLES + 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);
  localparam int              PAGES   = DATA_W / LED_W;
  localparam int              PG_W    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [PG_W-1:0] PG_LAST = PG_W'(PAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  logic [N_BTN-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_BTN-1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [N_BTN-1:0]                  db_q, db_d;
  logic [N_BTN-1:0]                  btn_raw, btn_s, press;

  state_t            state_q, state_d;
  logic              op_enc_q, op_enc_d;
  logic [DATA_W-1:0] text_q, text_d;
  logic              start_enc_q, start_enc_d;
  logic              start_dec_q, start_dec_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [PG_W-1:0]   page_q, page_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [ST_W-1:0]   stretch_q, stretch_d;

  // Synchroniser shift and debounce: count consecutive cycles of disagreement,
  // flip the debounced level at terminal count and flag a rising press.
  always_comb begin
    btn_raw = {btn_page, btn_dec, btn_enc};
    for (int i = 0; i < N_BTN; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      btn_s[i]    = sync_q[i][SYNC_STAGES-1];
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      press[i]    = 1'b0;
      if (btn_s[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_TC) begin
          db_d[i]  = btn_s[i];
          press[i] = btn_s[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Request FSM, start pulse generation, result capture and done stretch.
  always_comb begin
    state_d     = state_q;
    op_enc_d    = op_enc_q;
    text_d      = text_q;
    start_enc_d = 1'b0;
    start_dec_d = 1'b0;
    result_d    = result_q;
    stretch_d   = (stretch_q != '0) ? stretch_q - 1'b1 : stretch_q;
    case (state_q)
      S_IDLE: begin
        if (press[B_ENC] || press[B_DEC]) begin
          op_enc_d = press[B_ENC];
          text_d   = {BASE_TEXT, sw};
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (core_ready_i) begin
          start_enc_d = op_enc_q;
          start_dec_d = ~op_enc_q;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (core_done_i) begin
          result_d  = core_text_i;
          stretch_d = ST_LOAD;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LED page select with wrap; the window is registered from the current page.
  always_comb begin
    page_d = page_q;
    if (press[B_PAGE]) begin
      page_d = (page_q == PG_LAST) ? '0 : page_q + 1'b1;
    end
    led_d = result_q[page_q*LED_W +: LED_W];
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      db_q        <= '0;
      state_q     <= S_IDLE;
      op_enc_q    <= 1'b0;
      text_q      <= {BASE_TEXT, {SW_W{1'b0}}};
      start_enc_q <= 1'b0;
      start_dec_q <= 1'b0;
      result_q    <= '0;
      page_q      <= '0;
      led_q       <= '0;
      stretch_q   <= '0;
    end else begin
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      db_q        <= db_d;
      state_q     <= state_d;
      op_enc_q    <= op_enc_d;
      text_q      <= text_d;
      start_enc_q <= start_enc_d;
      start_dec_q <= start_dec_d;
      result_q    <= result_d;
      page_q      <= page_d;
      led_q       <= led_d;
      stretch_q   <= stretch_d;
    end
  end

  assign start_enc_o = start_enc_q;
  assign start_dec_o = start_dec_q;
  assign text_o      = text_q;
  assign led         = led_q;
  assign ready_o     = (state_q == S_IDLE) && core_ready_i;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (stretch_q != '0);

endmodule

// File: tb/tb_aes_board_ctrl.sv
// Self-checking bench for aes_board_ctrl with short debounce/stretch counts.
module tb_aes_board_ctrl;

  localparam logic [123:0] BASE = 124'h3243f6a8885a308d313198a2e037071;
  localparam logic [127:0] T1   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] T2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T3   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [1:0]   K_ENC = 2'b10;
  localparam logic [1:0]   K_DEC = 2'b01;

  logic         clk;
  logic         rst;
  logic [3:0]   sw;
  logic         btn_enc, btn_dec, btn_page;
  logic         core_ready_i, core_done_i;
  logic [127:0] core_text_i;
  logic         start_enc_o, start_dec_o;
  logic [127:0] text_o;
  logic [3:0]   led;
  logic         ready_o, busy_o, done_o;

  typedef struct packed {
    logic [1:0]   kind;
    logic [127:0] text;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_start  = 0;
  int   page_m   = 0;

  aes_board_ctrl #(
    .DATA_W(128), .SW_W(4), .LED_W(4), .BASE_TEXT(BASE),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_enc(btn_enc), .btn_dec(btn_dec), .btn_page(btn_page),
    .core_ready_i(core_ready_i), .core_done_i(core_done_i), .core_text_i(core_text_i),
    .start_enc_o(start_enc_o), .start_dec_o(start_dec_o), .text_o(text_o),
    .led(led), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_led(input logic [127:0] r, input int pg);
    return r[pg*4 +: 4];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_start(input logic [1:0] k, input logic [127:0] t);
    exp_t e;
    e.kind = k;
    e.text = t;
    exp_q.push_back(e);
  endtask

  task automatic press_btn(input int which);
    if (which == 0) btn_enc = 1'b1;
    else if (which == 1) btn_dec = 1'b1;
    else btn_page = 1'b1;
    tick(7);
    btn_enc = 1'b0; btn_dec = 1'b0; btn_page = 1'b0;
    tick(7);
  endtask

  task automatic wait_start(input string tag, input int bound);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk); #1;
      if (start_enc_o || start_dec_o) found = 1'b1;
    end
    chk(tag, 128'(found), 128'(1));
  endtask

  task automatic core_done_pulse(input logic [127:0] t);
    core_done_i = 1'b1;
    core_text_i = t;
    tick(1);
    core_done_i = 1'b0;
  endtask

  task automatic count_done(output int hi, output bit first);
    hi = 0;
    first = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) first = done_o;
      if (done_o) hi++;
    end
  endtask

  // Scoreboard: every start pulse must match the oldest expected request.
  always @(negedge clk) begin
    if (!rst && (start_enc_o || start_dec_o)) begin
      n_start++;
      if (exp_q.size() == 0) begin
        chk("start_unexpected", 128'({start_enc_o, start_dec_o}), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("start_kind", 128'({start_enc_o, start_dec_o}), 128'(mon_e.kind));
        chk("start_text", text_o, mon_e.text);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not complete");
  end

  initial begin
    int  base;
    int  hi;
    bit  first;
    bit  busy_seen;

    rst = 1'b1; sw = 4'h4; btn_enc = 1'b1; btn_dec = 1'b0; btn_page = 1'b0;
    core_ready_i = 1'b1; core_done_i = 1'b0; core_text_i = '0;
    tick(3);
    @(negedge clk);
    chk("rst_text",  text_o, {BASE, 4'h0});
    chk("rst_led",   128'(led), 128'(0));
    chk("rst_done",  128'(done_o), 128'(0));
    chk("rst_busy",  128'(busy_o), 128'(0));
    chk("rst_start", 128'({start_enc_o, start_dec_o}), 128'(0));
    chk("rst_ready", 128'(ready_o), 128'(1));

    // 1: button held through reset release gives exactly one encrypt start
    base = n_start;
    expect_start(K_ENC, 128'h3243f6a8885a308d313198a2e0370714);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_start("t1_start", 20);
    tick(8);
    chk("t1_one_start", 128'(n_start - base), 128'(1));
    chk("t1_busy", 128'(busy_o), 128'(1));
    chk("t1_ready_busy", 128'(ready_o), 128'(0));
    btn_enc = 1'b0;
    tick(8);
    chk("t1_busy_until_done", 128'(busy_o), 128'(1));
    core_done_pulse(128'h0);
    tick(12);
    chk("t1_idle", 128'(busy_o), 128'(0));

    // 2: short bounces never reach the debounced level
    base = n_start;
    btn_enc = 1'b1; tick(1); btn_enc = 1'b0; tick(1);
    btn_enc = 1'b1; tick(1); btn_enc = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | busy_o;
    end
    chk("t2_no_busy", 128'(busy_seen), 128'(0));
    chk("t2_no_start", 128'(n_start - base), 128'(0));

    // 3: decrypt waits in REQ for ready; enc press in REQ is dropped
    @(posedge clk); #1;
    base = n_start;
    core_ready_i = 1'b0;
    sw = 4'ha;
    expect_start(K_DEC, {BASE, 4'ha});
    btn_dec = 1'b1;
    tick(8);
    btn_dec = 1'b0;
    tick(2);
    sw = 4'h5;
    chk("t3_req_busy", 128'(busy_o), 128'(1));
    chk("t3_req_ready", 128'(ready_o), 128'(0));
    chk("t3_req_nostart", 128'(n_start - base), 128'(0));
    press_btn(0);
    chk("t3_enc_dropped", 128'(n_start - base), 128'(0));
    core_ready_i = 1'b1;
    wait_start("t3_start", 10);
    tick(10);
    chk("t3_one_start", 128'(n_start - base), 128'(1));
    chk("t3_text_held", text_o, {BASE, 4'ha});
    chk("t3_busy", 128'(busy_o), 128'(1));

    // 4: capture, stretch length and LED paging with wrap
    core_done_pulse(T1);
    count_done(hi, first);
    chk("t4_done_first", 128'(first), 128'(1));
    chk("t4_done_len", 128'(hi), 128'(8));
    chk("t4_led0", 128'(led), 128'(exp_led(T1, page_m)));
    chk("t4_idle", 128'(busy_o), 128'(0));
    for (int p = 0; p < 32; p++) begin
      press_btn(2);
      page_m = (page_m + 1) % 32;
      chk("t4_page_led", 128'(led), 128'(exp_led(T1, page_m)));
    end
    chk("t4_wrap_led", 128'(led), 128'(4'h2));

    // 5: second capture during stretch reloads the full count
    expect_start(K_ENC, {BASE, 4'h5});
    btn_enc = 1'b1;
    wait_start("t5_start1", 12);
    btn_enc = 1'b0;
    tick(8);
    btn_enc = 1'b1;
    expect_start(K_ENC, {BASE, 4'h5});
    tick(3);
    core_done_i = 1'b1;
    core_text_i = T2;
    tick(1);
    core_done_i = 1'b0;
    wait_start("t5_start2", 10);
    chk("t5_done_held", 128'(done_o), 128'(1));
    core_done_i = 1'b1;
    core_text_i = T3;
    @(posedge clk); #1;
    core_done_i = 1'b0;
    btn_enc = 1'b0;
    count_done(hi, first);
    chk("t5_reload_first", 128'(first), 128'(1));
    chk("t5_reload_len", 128'(hi), 128'(8));
    chk("t5_led", 128'(led), 128'(exp_led(T3, page_m)));
    core_done_pulse(T2);
    tick(2);
    chk("t5_idle_done_ignored", 128'(led), 128'(exp_led(T3, page_m)));
    chk("t5_idle_no_stretch", 128'(done_o), 128'(0));
    chk("t5_idle_busy", 128'(busy_o), 128'(0));

    // 6: reset during BUSY aborts; page and result are cleared
    press_btn(2);
    page_m = (page_m + 1) % 32;
    chk("t6_page1_led", 128'(led), 128'(exp_led(T3, page_m)));
    expect_start(K_ENC, {BASE, 4'h5});
    btn_enc = 1'b1;
    wait_start("t6_start", 12);
    btn_enc = 1'b0;
    tick(2);
    chk("t6_busy_before", 128'(busy_o), 128'(1));
    rst = 1'b1;
    tick(1);
    chk("t6_rst_busy", 128'(busy_o), 128'(0));
    chk("t6_rst_led", 128'(led), 128'(0));
    chk("t6_rst_done", 128'(done_o), 128'(0));
    chk("t6_rst_text", text_o, {BASE, 4'h0});
    rst = 1'b0;
    page_m = 0;
    tick(8);
    core_done_pulse(T3);
    tick(2);
    chk("t6_done_ignored_led", 128'(led), 128'(0));
    chk("t6_done_ignored_done", 128'(done_o), 128'(0));
    expect_start(K_ENC, {BASE, 4'h5});
    btn_enc = 1'b1;
    wait_start("t6_start2", 12);
    btn_enc = 1'b0;
    tick(3);
    core_done_pulse(T1);
    tick(2);
    chk("t6_page_reset_led", 128'(led), 128'(exp_led(T1, page_m)));
    chk("t6_done_high", 128'(done_o), 128'(1));
    rst = 1'b1;
    tick(1);
    chk("t6_rst_stretch", 128'(done_o), 128'(0));
    chk("t6_rst_led2", 128'(led), 128'(0));
    rst = 1'b0;
    tick(4);

    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
